// File: rtl/c2c_slave_burst_rx_if.sv
// rtl/c2c_slave_burst_rx_if.sv - chip-to-chip burst handshake bundle
//
// Ports (signals of the bundle):
//   request, valid, data_in         master -> slave request, word-valid and word
//   ack, data_ack, notice           slave handshake and LED indication
//   data, data_done                 assembled burst and its one-cycle update pulse
//   timeout_err, busy               sticky timeout flag and not-idle status
interface c2c_slave_burst_rx_if #(
  parameter int DATA_W    = 3,
  parameter int BURST_LEN = 2
);
  logic                          request;
  logic                          valid;
  logic [DATA_W-1:0]             data_in;
  logic                          ack;
  logic                          data_ack;
  logic                          notice;
  logic [DATA_W*BURST_LEN-1:0]   data;
  logic                          data_done;
  logic                          timeout_err;
  logic                          busy;

  modport master (
    output request, valid, data_in,
    input  ack, data_ack, notice, data, data_done, timeout_err, busy
  );

  modport slave (
    input  request, valid, data_in,
    output ack, data_ack, notice, data, data_done, timeout_err, busy
  );
endinterface

// File: rtl/c2c_slave_burst_rx.sv
// rtl/c2c_slave_burst_rx.sv - chip-to-chip slave receiving one burst per request
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  c2c_slave_burst_rx_if.slave: request/valid/data_in from the master pins,
//        ack/data_ack/notice/data/data_done/timeout_err/busy registered outputs
module c2c_slave_burst_rx #(
  parameter int DATA_W    = 3,
  parameter int BURST_LEN = 2,
  parameter int ACK_DELAY = 100_000_000,
  parameter int TIMEOUT   = 200_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  c2c_slave_burst_rx_if.slave   bus
);
  localparam int MAXP = (ACK_DELAY > TIMEOUT) ? ACK_DELAY : TIMEOUT;
  localparam int CW   = $clog2(MAXP + 1) + 1;
  localparam int IW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] DELAY_LOAD = CW'(ACK_DELAY - 1);
  localparam logic [CW-1:0] TIMER_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, NOTICE, WAIT_VALID, WAIT_VALID_LOW, WAIT_RQ_LOW
  } state_t;

  // Two-flop synchronisers for the asynchronous master pins
  logic request_m, request_s, valid_m, valid_s;

  state_t                                   state, state_n;
  logic [CW-1:0]                            delay_cnt, delay_cnt_n;
  logic [CW-1:0]                            timer, timer_n;
  logic [IW-1:0]                            idx, idx_n;
  logic [BURST_LEN-1:0][DATA_W-1:0]         shadow, shadow_n;
  logic [DATA_W*BURST_LEN-1:0]              data_r, data_n;
  logic ack_r, ack_n, data_ack_r, data_ack_n, notice_r, notice_n;
  logic done_r, done_n, terr_r, terr_n, busy_r, busy_n;
  logic timer_expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      request_m <= 1'b0;
      request_s <= 1'b0;
      valid_m   <= 1'b0;
      valid_s   <= 1'b0;
    end else begin
      request_m <= bus.request;
      request_s <= request_m;
      valid_m   <= bus.valid;
      valid_s   <= valid_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      delay_cnt  <= '0;
      timer      <= '0;
      idx        <= '0;
      shadow     <= '0;
      data_r     <= '0;
      ack_r      <= 1'b0;
      data_ack_r <= 1'b0;
      notice_r   <= 1'b0;
      done_r     <= 1'b0;
      terr_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state      <= state_n;
      delay_cnt  <= delay_cnt_n;
      timer      <= timer_n;
      idx        <= idx_n;
      shadow     <= shadow_n;
      data_r     <= data_n;
      ack_r      <= ack_n;
      data_ack_r <= data_ack_n;
      notice_r   <= notice_n;
      done_r     <= done_n;
      terr_r     <= terr_n;
      busy_r     <= busy_n;
    end
  end

  // A zero TIMEOUT never expires and the timer is left parked at 0
  assign timer_expired = (TIMEOUT != 0) && (timer == TIMER_LAST);

  always_comb begin
    state_n     = state;
    delay_cnt_n = delay_cnt;
    timer_n     = timer;
    idx_n       = idx;
    shadow_n    = shadow;
    data_n      = data_r;
    ack_n       = ack_r;
    data_ack_n  = data_ack_r;
    notice_n    = notice_r;
    done_n      = 1'b0;
    terr_n      = terr_r;

    case (state)
      IDLE: begin
        if (request_s) begin
          state_n     = NOTICE;
          notice_n    = 1'b1;
          delay_cnt_n = DELAY_LOAD;
          terr_n      = 1'b0;
        end
      end
      NOTICE: begin
        if (!request_s) begin
          state_n  = IDLE;
          notice_n = 1'b0;
        end else if (delay_cnt == '0) begin
          state_n  = WAIT_VALID;
          notice_n = 1'b0;
          ack_n    = 1'b1;
          idx_n    = '0;
          timer_n  = '0;
        end else begin
          delay_cnt_n = delay_cnt - CW'(1);
        end
      end
      WAIT_VALID, WAIT_VALID_LOW: begin
        // Abort outranks capture, completion and timeout
        if (!request_s) begin
          state_n    = IDLE;
          ack_n      = 1'b0;
          data_ack_n = 1'b0;
        end else if ((state == WAIT_VALID) && valid_s) begin
          shadow_n[idx] = bus.data_in;
          data_ack_n    = 1'b1;
          timer_n       = '0;
          state_n       = WAIT_VALID_LOW;
        end else if ((state == WAIT_VALID_LOW) && !valid_s) begin
          data_ack_n = 1'b0;
          if (idx == IDX_LAST) begin
            data_n  = shadow;
            done_n  = 1'b1;
            ack_n   = 1'b0;
            state_n = WAIT_RQ_LOW;
          end else begin
            idx_n   = idx + IW'(1);
            timer_n = '0;
            state_n = WAIT_VALID;
          end
        end else if (timer_expired) begin
          terr_n     = 1'b1;
          ack_n      = 1'b0;
          data_ack_n = 1'b0;
          state_n    = WAIT_RQ_LOW;
        end else if (TIMEOUT != 0) begin
          timer_n = timer + CW'(1);
        end
      end
      WAIT_RQ_LOW: begin
        if (!request_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  assign bus.ack         = ack_r;
  assign bus.data_ack    = data_ack_r;
  assign bus.notice      = notice_r;
  assign bus.data        = data_r;
  assign bus.data_done   = done_r;
  assign bus.timeout_err = terr_r;
  assign bus.busy        = busy_r;
endmodule

// File: tb/tb_c2c_slave_burst_rx.sv
// tb/tb_c2c_slave_burst_rx.sv - directed bench for c2c_slave_burst_rx
module tb_c2c_slave_burst_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   done_a_cnt = 0;
  int   done_b_cnt = 0;

  always #5 clk = ~clk;

  c2c_slave_burst_rx_if #(.DATA_W(3), .BURST_LEN(2)) bus_a ();
  c2c_slave_burst_rx_if #(.DATA_W(3), .BURST_LEN(1)) bus_b ();

  c2c_slave_burst_rx #(.DATA_W(3), .BURST_LEN(2), .ACK_DELAY(4), .TIMEOUT(16)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  c2c_slave_burst_rx #(.DATA_W(3), .BURST_LEN(1), .ACK_DELAY(1), .TIMEOUT(0)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  always @(negedge clk) begin
    if (bus_a.data_done) done_a_cnt++;
    if (bus_b.data_done) done_b_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    step(2);
    checks++; if ({bus_a.ack, bus_a.data_ack, bus_a.notice, bus_a.data_done, bus_a.timeout_err, bus_a.busy} !== 6'b0)
      begin failures++; $display("FAIL reset_flags_a got=%b exp=000000", {bus_a.ack, bus_a.data_ack, bus_a.notice, bus_a.data_done, bus_a.timeout_err, bus_a.busy}); end
    checks++; if (bus_a.data !== 6'h00) begin failures++; $display("FAIL reset_data_a got=%0h exp=0", bus_a.data); end
    checks++; if ({bus_b.ack, bus_b.notice, bus_b.busy, bus_b.data} !== 6'b0)
      begin failures++; $display("FAIL reset_b got=%b exp=000000", {bus_b.ack, bus_b.notice, bus_b.busy, bus_b.data}); end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_normal_burst;
    int d0;
    d0 = done_a_cnt;
    bus_a.request = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step(1);
      checks++; if (bus_a.notice !== ((e >= 3) && (e <= 6)))
        begin failures++; $display("FAIL burst_notice_e%0d got=%b", e, bus_a.notice); end
      checks++; if (bus_a.ack !== (e >= 7))
        begin failures++; $display("FAIL burst_ack_e%0d got=%b", e, bus_a.ack); end
      checks++; if (bus_a.busy !== (e >= 3))
        begin failures++; $display("FAIL burst_busy_e%0d got=%b", e, bus_a.busy); end
    end
    // first word 3'b101
    bus_a.data_in = 3'b101; bus_a.valid = 1'b1;
    step(2);
    checks++; if (bus_a.data_ack !== 1'b0) begin failures++; $display("FAIL w0_data_ack_early got=%b exp=0", bus_a.data_ack); end
    step(1);
    checks++; if (bus_a.data_ack !== 1'b1) begin failures++; $display("FAIL w0_data_ack got=%b exp=1", bus_a.data_ack); end
    bus_a.valid = 1'b0;
    step(3);
    checks++; if ({bus_a.data_ack, bus_a.ack, bus_a.data_done} !== 3'b010)
      begin failures++; $display("FAIL w0_release got=%b exp=010", {bus_a.data_ack, bus_a.ack, bus_a.data_done}); end
    // second word 3'b010
    bus_a.data_in = 3'b010; bus_a.valid = 1'b1;
    step(3);
    checks++; if (bus_a.data_ack !== 1'b1) begin failures++; $display("FAIL w1_data_ack got=%b exp=1", bus_a.data_ack); end
    bus_a.valid = 1'b0;
    step(3);
    checks++; if (bus_a.data !== 6'b010_101) begin failures++; $display("FAIL burst_data got=%b exp=010101", bus_a.data); end
    checks++; if ({bus_a.data_done, bus_a.ack, bus_a.data_ack} !== 3'b100)
      begin failures++; $display("FAIL burst_done got=%b exp=100", {bus_a.data_done, bus_a.ack, bus_a.data_ack}); end
    step(1);
    checks++; if (bus_a.data_done !== 1'b0) begin failures++; $display("FAIL burst_done_width got=%b exp=0", bus_a.data_done); end
    checks++; if (done_a_cnt - d0 !== 1) begin failures++; $display("FAIL burst_done_count got=%0d exp=1", done_a_cnt - d0); end
  endtask

  task automatic test_hold_request;
    int d0;
    d0 = done_a_cnt;
    step(50);
    checks++; if (bus_a.busy !== 1'b1) begin failures++; $display("FAIL hold_busy got=%b exp=1", bus_a.busy); end
    checks++; if ({bus_a.ack, bus_a.notice} !== 2'b00) begin failures++; $display("FAIL hold_no_restart got=%b exp=00", {bus_a.ack, bus_a.notice}); end
    checks++; if (done_a_cnt !== d0) begin failures++; $display("FAIL hold_extra_done got=%0d exp=%0d", done_a_cnt, d0); end
    bus_a.request = 1'b0;
    step(2);
    checks++; if (bus_a.busy !== 1'b1) begin failures++; $display("FAIL hold_busy_sync got=%b exp=1", bus_a.busy); end
    step(1);
    checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("FAIL hold_idle got=%b exp=0", bus_a.busy); end
  endtask

  task automatic test_timeout;
    int d0;
    d0 = done_a_cnt;
    bus_a.request = 1'b1;
    step(7);
    checks++; if (bus_a.ack !== 1'b1) begin failures++; $display("FAIL to_ack got=%b exp=1", bus_a.ack); end
    step(15);
    checks++; if ({bus_a.ack, bus_a.timeout_err} !== 2'b10)
      begin failures++; $display("FAIL to_early got=%b exp=10", {bus_a.ack, bus_a.timeout_err}); end
    step(1);
    checks++; if ({bus_a.ack, bus_a.timeout_err, bus_a.data_ack} !== 3'b010)
      begin failures++; $display("FAIL to_fire got=%b exp=010", {bus_a.ack, bus_a.timeout_err, bus_a.data_ack}); end
    checks++; if (bus_a.data !== 6'b010_101) begin failures++; $display("FAIL to_data got=%b exp=010101", bus_a.data); end
    checks++; if (done_a_cnt !== d0) begin failures++; $display("FAIL to_done got=%0d exp=%0d", done_a_cnt, d0); end
    bus_a.request = 1'b0;
    step(3);
    checks++; if ({bus_a.busy, bus_a.timeout_err} !== 2'b01)
      begin failures++; $display("FAIL to_sticky got=%b exp=01", {bus_a.busy, bus_a.timeout_err}); end
    bus_a.request = 1'b1;
    step(3);
    checks++; if ({bus_a.notice, bus_a.timeout_err} !== 2'b10)
      begin failures++; $display("FAIL to_clear got=%b exp=10", {bus_a.notice, bus_a.timeout_err}); end
    bus_a.request = 1'b0;
    step(3);
    checks++; if ({bus_a.busy, bus_a.notice} !== 2'b00)
      begin failures++; $display("FAIL notice_abort got=%b exp=00", {bus_a.busy, bus_a.notice}); end
  endtask

  task automatic test_abort;
    int d0;
    d0 = done_a_cnt;
    bus_a.request = 1'b1;
    step(7);
    bus_a.data_in = 3'b011; bus_a.valid = 1'b1;
    step(3);
    checks++; if (bus_a.data_ack !== 1'b1) begin failures++; $display("FAIL ab_capture got=%b exp=1", bus_a.data_ack); end
    bus_a.request = 1'b0;
    step(2);
    checks++; if (bus_a.busy !== 1'b1) begin failures++; $display("FAIL ab_busy_sync got=%b exp=1", bus_a.busy); end
    step(1);
    checks++; if ({bus_a.busy, bus_a.ack, bus_a.data_ack} !== 3'b000)
      begin failures++; $display("FAIL ab_idle got=%b exp=000", {bus_a.busy, bus_a.ack, bus_a.data_ack}); end
    checks++; if (bus_a.data !== 6'b010_101) begin failures++; $display("FAIL ab_data got=%b exp=010101", bus_a.data); end
    bus_a.valid = 1'b0;
    step(3);
    checks++; if (done_a_cnt !== d0) begin failures++; $display("FAIL ab_done got=%0d exp=%0d", done_a_cnt, d0); end
  endtask

  task automatic test_reset_mid_notice;
    bus_a.request = 1'b1;
    step(4);
    checks++; if (bus_a.notice !== 1'b1) begin failures++; $display("FAIL rst_pre_notice got=%b exp=1", bus_a.notice); end
    checks++; if (bus_a.data !== 6'b010_101) begin failures++; $display("FAIL rst_pre_data got=%b exp=010101", bus_a.data); end
    rst = 1'b1;
    #1;
    checks++; if ({bus_a.ack, bus_a.data_ack, bus_a.notice, bus_a.data_done, bus_a.timeout_err, bus_a.busy} !== 6'b0)
      begin failures++; $display("FAIL rst_async_flags got=%b exp=000000", {bus_a.ack, bus_a.data_ack, bus_a.notice, bus_a.data_done, bus_a.timeout_err, bus_a.busy}); end
    checks++; if (bus_a.data !== 6'h00) begin failures++; $display("FAIL rst_async_data got=%b exp=000000", bus_a.data); end
    bus_a.request = 1'b0;
    step(2);
    rst = 1'b0;
    step(3);
    checks++; if ({bus_a.busy, bus_a.notice} !== 2'b00)
      begin failures++; $display("FAIL rst_release got=%b exp=00", {bus_a.busy, bus_a.notice}); end
  endtask

  task automatic test_edge_config;
    int d0;
    d0 = done_b_cnt;
    bus_b.request = 1'b1;
    step(3);
    checks++; if ({bus_b.notice, bus_b.ack} !== 2'b10) begin failures++; $display("FAIL b_notice got=%b exp=10", {bus_b.notice, bus_b.ack}); end
    step(1);
    checks++; if ({bus_b.notice, bus_b.ack} !== 2'b01) begin failures++; $display("FAIL b_ack got=%b exp=01", {bus_b.notice, bus_b.ack}); end
    step(1000);
    checks++; if ({bus_b.ack, bus_b.timeout_err, bus_b.busy} !== 3'b101)
      begin failures++; $display("FAIL b_stall got=%b exp=101", {bus_b.ack, bus_b.timeout_err, bus_b.busy}); end
    bus_b.data_in = 3'b111; bus_b.valid = 1'b1;
    step(3);
    checks++; if (bus_b.data_ack !== 1'b1) begin failures++; $display("FAIL b_data_ack got=%b exp=1", bus_b.data_ack); end
    bus_b.valid = 1'b0;
    step(3);
    checks++; if (bus_b.data !== 3'b111) begin failures++; $display("FAIL b_data got=%b exp=111", bus_b.data); end
    checks++; if ({bus_b.data_done, bus_b.ack} !== 2'b10) begin failures++; $display("FAIL b_done got=%b exp=10", {bus_b.data_done, bus_b.ack}); end
    bus_b.request = 1'b0;
    step(3);
    checks++; if (bus_b.busy !== 1'b0) begin failures++; $display("FAIL b_idle got=%b exp=0", bus_b.busy); end
    checks++; if (done_b_cnt - d0 !== 1) begin failures++; $display("FAIL b_done_count got=%0d exp=1", done_b_cnt - d0); end
  endtask

  initial begin
    bus_a.request = 1'b0; bus_a.valid = 1'b0; bus_a.data_in = '0;
    bus_b.request = 1'b0; bus_b.valid = 1'b0; bus_b.data_in = '0;
    test_reset();
    test_normal_burst();
    test_hold_request();
    test_timeout();
    test_abort();
    test_reset_mid_notice();
    test_edge_config();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/c2c_slave_burst_rx.md
Name: c2c_slave_burst_rx

Overview:
- Parametrised next-generation chip-to-chip slave controller.
- Accepts a master request, holds a notice indication for a programmable delay, then raises ack.
- Receives a burst of BURST_LEN words over a per-word valid/data_ack handshake and publishes the assembled burst.
- Adds input synchronisers, built-in delay counting, a receive timeout and abort handling. Sits between the board pins and the display/consumer logic.

Parameters:
- DATA_W, 3: width of one data word.
- BURST_LEN, 2: words per transaction, legal range 1..16.
- ACK_DELAY, 100_000_000: cycles notice is held before ack (1 s at 100 MHz); minimum 1.
- TIMEOUT, 200_000_000: maximum cycles spent in a wait-for-master state; 0 disables the timeout.

Ports:
- clk, input, 1: system clock, all logic on the rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- request, input, 1: master request, asynchronous to clk, level.
- valid, input, 1: master word-valid, asynchronous to clk, level.
- data_in, input, DATA_W: word from master, stable while valid is high.
- ack, output, 1: slave ready for the burst.
- data_ack, output, 1: per-word acknowledge.
- notice, output, 1: LED indication during the ack delay.
- data, output, DATA_W*BURST_LEN: last completed burst; word 0 in the LSBs.
- data_done, output, 1: one-cycle pulse when data updates.
- timeout_err, output, 1: sticky timeout flag.
- busy, output, 1: high whenever state is not IDLE.

Behaviour:
- Reset (async assert): state IDLE; ack, data_ack, notice, data_done, timeout_err, busy = 0; data = 0; word index, delay counter, timer and shadow register = 0.
- Synchronisers: request and valid each pass through a 2-FF synchroniser to give request_s and valid_s. The FSM acts only on request_s and valid_s. A pin edge becomes visible to the FSM after 2 edges; the resulting output changes on the 3rd edge.
- data_in is sampled directly when valid_s is seen high; the master guarantees setup.
- All outputs are registered.
- States:
  - IDLE: ack=0, data_ack=0, notice=0. On request_s=1: go to NOTICE, set notice=1, load the delay counter with ACK_DELAY-1, clear timeout_err.
  - NOTICE: counter decrements each cycle. When it reaches 0: go to WAIT_VALID, notice=0, ack=1, word index=0, timer=0. notice is therefore high for exactly ACK_DELAY cycles.
  - WAIT_VALID: on valid_s=1, store data_in into shadow word[index], set data_ack=1, go to WAIT_VALID_LOW, timer=0.
  - WAIT_VALID_LOW: on valid_s=0, set data_ack=0.
    - If index = BURST_LEN-1: data <= shadow, data_done=1 for one cycle, ack=0, go to WAIT_RQ_LOW.
    - Otherwise: index+1, timer=0, go to WAIT_VALID.
  - WAIT_RQ_LOW: on request_s=0, go to IDLE. A request held high after completion never starts a second burst.
- Timeout: the timer counts in WAIT_VALID and WAIT_VALID_LOW only. When timer reaches TIMEOUT-1 with the awaited event absent:
  - timeout_err=1, ack=0, data_ack=0;
  - shadow discarded, data unchanged, no data_done;
  - go to WAIT_RQ_LOW.
  - timeout_err stays set until the next accepted request.
- Abort: request_s=0 in NOTICE, WAIT_VALID or WAIT_VALID_LOW returns to IDLE next edge.
  - All handshake outputs drop to 0; data unchanged; timeout_err unchanged.
  - Abort has priority over capture, completion and timeout in the same cycle.
- Reset mid-operation: immediate return to reset values, including data.
- Timer and delay counter widths: $clog2 of the maximum parameter value + 1. The word index has no wrap beyond BURST_LEN-1.

Test Plan:
- Reset: assert rst mid-NOTICE -> all outputs 0 asynchronously (before the next clk edge); state IDLE after release.
- Normal burst (DATA_W=3, BURST_LEN=2, ACK_DELAY=4, TIMEOUT=16), request rises before edge 1 ->
  - notice high for edges 3..6, ack high from edge 7;
  - words 3'b101 then 3'b010, each with a valid pulse -> data_ack follows each valid 3 edges later;
  - data=6'b010_101, data_done high for exactly 1 cycle, ack=0.
- Timeout: same config, ack high, valid never asserted -> after 16 cycles in WAIT_VALID: timeout_err=1, ack=0, data unchanged. Drop request -> IDLE. New request -> timeout_err clears.
- Abort: drop request after the first word is captured -> IDLE within 3 edges, ack=0, data_ack=0, data keeps its prior value, no data_done.
- Hold request high for 50 cycles after data_done -> exactly one burst, busy=1 until request falls, then busy=0.
- Edge config BURST_LEN=1, ACK_DELAY=1, TIMEOUT=0 -> notice high for 1 cycle; single word 3'b111 gives data=3'b111; a 1000-cycle stall produces no timeout.
